// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : RISC-V MEM stage; loads/stores as byte sequences on a req/ack port
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [31:0]       ex_wdata,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_sdata,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [31:0]       mem_wdata,
  output logic              stallreq,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  input  logic              ram_ack
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [1:0]        r_idx;
  logic [31:0]       r_buf;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_dout;

  logic              w_legal;
  logic [1:0]        w_last_idx;
  logic              w_mem_op;
  logic              w_last;
  logic [1:0]        w_next_idx;
  logic [31:0]       w_load_val;

  always_comb begin
    w_legal    = 1'b1;
    w_last_idx = 2'd0;
    case (ex_funct3)
      3'b000, 3'b100: w_last_idx = 2'd0;
      3'b001, 3'b101: w_last_idx = 2'd1;
      3'b010:         w_last_idx = 2'd3;
      default:        w_legal    = 1'b0;
    endcase
  end

  assign w_mem_op   = (ex_is_load | ex_is_store) & w_legal;
  assign w_last     = (r_idx == w_last_idx);
  assign w_next_idx = r_idx + 2'd1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_mem_op) w_next_state = S_ACCESS;
      S_ACCESS: if (ram_ack && w_last) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Byte-transaction datapath; the next byte is presented right after an ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= 2'd0;
      r_buf  <= 32'd0;
      r_req  <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_dout <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_idx  <= 2'd0;
            r_req  <= 1'b1;
            r_we   <= ex_is_store;
            r_addr <= ex_addr[ADDR_W-1:0];
            r_dout <= ex_sdata[7:0];
          end
        end
        S_ACCESS: begin
          if (ram_ack) begin
            if (ex_is_load) r_buf[8*r_idx +: 8] <= ram_din;
            if (w_last) begin
              r_req <= 1'b0;
            end else begin
              r_idx  <= w_next_idx;
              r_addr <= ex_addr[ADDR_W-1:0] + ADDR_W'(w_next_idx);
              r_dout <= ex_sdata[8*w_next_idx +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_req  = r_req;
  assign ram_we   = r_we;
  assign ram_addr = r_addr;
  assign ram_dout = r_dout;

  always_comb begin
    w_load_val = r_buf;
    case (ex_funct3)
      3'b000:  w_load_val = {{24{r_buf[7]}}, r_buf[7:0]};
      3'b100:  w_load_val = {24'd0, r_buf[7:0]};
      3'b001:  w_load_val = {{16{r_buf[15]}}, r_buf[15:0]};
      3'b101:  w_load_val = {16'd0, r_buf[15:0]};
      default: w_load_val = r_buf;
    endcase
  end

  // Output logic; reset forces the write-back triple to a bubble
  always_comb begin
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;
    stallreq  = 1'b0;
    if (!rst) begin
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            stallreq = 1'b1;
            mem_wreg = 1'b0;
          end else if (ex_is_load | ex_is_store) begin
            mem_wdata = 32'd0;
          end
        end
        S_ACCESS: begin
          stallreq = 1'b1;
          mem_wreg = 1'b0;
        end
        S_DONE: begin
          if (ex_is_load && !ex_is_store) mem_wdata = w_load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Randomized/directed bench for mem_stage with a byte-memory model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  d;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_sdata = '0;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic        mem_ack = 1'b0;
  logic        spur_ack = 1'b0;
  wire         ram_ack = mem_ack | spur_ack;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cnt = 0;
  int unstable = 0;
  txn_t log_q[$];
  logic [7:0] mem [int unsigned];
  txn_t hold;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_sdata(ex_sdata),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .stallreq(stallreq),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_din(ram_din), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Byte memory: acks each request after lat cycles, logs every transaction
  always @(negedge clk) begin
    if (rst && ram_req) begin
      if (cnt > 0 && (hold !== {ram_we, ram_addr, ram_dout})) unstable++;
      hold = {ram_we, ram_addr, ram_dout};
      if (cnt >= lat - 1) begin
        mem_ack = 1'b1;
        ram_din = rd(ram_addr);
        if (ram_we) mem[ram_addr] = ram_dout;
        log_q.push_back(hold);
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
        ram_din = 8'($urandom);
        cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      ram_din = 8'($urandom);
      cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access size from funct3, little-endian bytes, extension by type
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
    int v;
    case (f3)
      3'b000:  v = $signed(b0);
      3'b100:  v = b0;
      3'b001:  v = $signed({b1, b0});
      3'b101:  v = {b1, b0};
      default: v = {b3, b2, b1, b0};
    endcase
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge after write-back
  task automatic do_op(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input int l);
    int n;
    int stall;
    int bad_wreg;
    logic [7:0] b [4];
    logic [31:0] sd;
    n = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 :
        (f3 == 3'b010) ? 4 : 0;
    for (int i = 0; i < 4; i++) b[i] = rd(addr + 32'(i));
    lat = l;
    log_q.delete();
    unstable = 0;
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = addr; ex_sdata = sdata;
    #1;
    if (!(ld || st) || n == 0) begin
      chk("pass_wd", 32'(mem_wd), 32'(wd));
      chk("pass_wreg", 32'(mem_wreg), 32'(wreg));
      chk("pass_wdata", mem_wdata, (ld || st) ? 32'd0 : wdata);
      chk("pass_stall", 32'(stallreq), 32'd0);
      @(negedge clk);
      chk("pass_noreq", 32'(ram_req), 32'd0);
      return;
    end
    chk("idle_stall", 32'(stallreq), 32'd1);
    chk("idle_bubble", 32'(mem_wreg), 32'd0);
    stall = 1;
    bad_wreg = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (!stallreq) break;
      stall++;
      if (mem_wreg !== 1'b0) bad_wreg++;
    end
    chk("stall_cycles", 32'(stall), 32'(1 + n * l));
    chk("stall_bubble", 32'(bad_wreg), 32'd0);
    chk("done_wd", 32'(mem_wd), 32'(wd));
    chk("done_wreg", 32'(mem_wreg), 32'(wreg));
    chk("done_wdata", mem_wdata, ld ? ref_load(f3, b[0], b[1], b[2], b[3]) : wdata);
    chk("done_req", 32'(ram_req), 32'd0);
    chk("txn_count", 32'(log_q.size()), 32'(n));
    sd = sdata;
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      chk("txn_addr", log_q[i].addr, addr + 32'(i));
      chk("txn_we", 32'(log_q[i].we), 32'(st));
      if (st) chk("txn_dout", 32'(log_q[i].d), 32'(sd[7:0]));
      sd = sd >> 8;
    end
    chk("txn_stable", 32'(unstable), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    logic [2:0] bad_f3 [3];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f3 = '{3'b000, 3'b001, 3'b010};
    bad_f3 = '{3'b011, 3'b110, 3'b111};
    for (int a = 0; a < 1100; a++) mem[a] = 8'($urandom);
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    mem[32'h201] = 8'h80; mem[32'h203] = 8'hFE; mem[32'h204] = 8'h7F;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(ram_req), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_dout", 32'(ram_dout), 32'd0);
    chk("rst_stall", 32'(stallreq), 32'd0);
    chk("rst_wreg", 32'(mem_wreg), 32'd0);
    chk("rst_wd", 32'(mem_wd), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op(5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1);
    do_op(5'd7, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1);
    do_op(5'd8, 1'b1, 32'h0, 1'b1, 1'b0, 3'b000, 32'h201, 32'h0, 1);
    do_op(5'd9, 1'b1, 32'h0, 1'b1, 1'b0, 3'b100, 32'h201, 32'h0, 2);
    do_op(5'd10, 1'b1, 32'h0, 1'b1, 1'b0, 3'b001, 32'h203, 32'h0, 1);
    do_op(5'd0, 1'b0, 32'h55, 1'b0, 1'b1, 3'b010, 32'h300, 32'hDEADBEEF, 3);
    do_op(5'd11, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1);
    do_op(5'd12, 1'b1, 32'hCAFE, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1);
    spur_ack = 1'b1;
    do_op(5'd13, 1'b1, 32'h77, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1);
    spur_ack = 1'b0;
    do_op(5'd14, 1'b1, 32'h99, 1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 1);

    // Reset in the middle of byte 2 of a store
    lat = 2;
    log_q.delete();
    ex_wd = 5'd0; ex_wreg = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b1;
    ex_funct3 = 3'b010; ex_addr = 32'h380; ex_sdata = 32'h01020304;
    for (int c = 0; c < 100 && log_q.size() < 2; c++) @(posedge clk);
    chk("rst_reach_b2", 32'(log_q.size()), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_req", 32'(ram_req), 32'd0);
    chk("async_rst_stall", 32'(stallreq), 32'd0);
    ex_is_store = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_op(5'd15, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1);

    for (int k = 0; k < 25; k++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_op(5'($urandom), 1'($urandom), $urandom, 1'b0, 1'b0, 3'($urandom), 32'h0, 32'h0, 1);
        1: do_op(5'($urandom), 1'b1, $urandom, 1'b1, 1'b0, ld_f3[$urandom_range(0, 4)],
                 32'($urandom_range(0, 1023)), $urandom, $urandom_range(1, 3));
        2: do_op(5'($urandom), 1'b0, $urandom, 1'b0, 1'b1, st_f3[$urandom_range(0, 2)],
                 32'($urandom_range(0, 1023)), $urandom, $urandom_range(1, 3));
        default: do_op(5'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'b1,
                       bad_f3[$urandom_range(0, 2)], 32'($urandom_range(0, 1023)), $urandom, 1);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Non-memory instructions pass straight through in zero cycles.
- Loads and stores run as a sequence of byte transactions on an 8-bit req/ack memory port. The stage stalls the pipeline until the sequence completes, then presents the write-back triple (wd, wreg, wdata) to MEM/WB.

Parameters:
ADDR_W, 32, width of the byte address driven to memory (low ADDR_W bits of the effective address).

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
ex_wd  in  5  destination register from EX/MEM
ex_wreg  in  1  register write enable from EX/MEM
ex_wdata  in  32  ALU result (non-memory ops)
ex_is_load  in  1  instruction is a load
ex_is_store  in  1  instruction is a store
ex_funct3  in  3  RISC-V funct3 (access size and sign)
ex_addr  in  32  effective address
ex_sdata  in  32  store data (rs2)
mem_wd  out  5  to MEM/WB
mem_wreg  out  1  to MEM/WB
mem_wdata  out  32  to MEM/WB
stallreq  out  1  freeze PC/IF/ID/EX/EX-MEM; bubble into MEM/WB
ram_req  out  1  byte transaction request
ram_we  out  1  1 = write, 0 = read
ram_addr  out  ADDR_W  byte address
ram_dout  out  8  write byte
ram_din  in  8  read byte, valid in ack cycle
ram_ack  in  1  transaction complete (1-cycle pulse)

Behaviour:
- Reset (rst = 0, async):
  - state = IDLE, byte index = 0, assembly buffer = 0.
  - ram_req = 0, ram_we = 0, ram_addr = 0, ram_dout = 0.
  - stallreq = 0, mem_wreg = 0, mem_wd = 0, mem_wdata = 0.
  - Reset mid-sequence abandons it. ram_req drops immediately, without waiting for a clock.
- Access size N, from funct3:
  - 000/100 → N = 1 (LB/LBU, SB).
  - 001/101 → N = 2 (LH/LHU, SH).
  - 010 → N = 4 (LW, SW).
  - Any other funct3 with is_load/is_store set is illegal: no memory access, no stall. Outputs mem_wd = ex_wd, mem_wreg = ex_wreg, mem_wdata = 0.
- Byte order is little-endian.
  - Transaction i (0..N-1) uses ram_addr = ex_addr + i (truncated to ADDR_W).
  - Misalignment is permitted and needs no special handling.
  - For stores, ram_dout = ex_sdata[8i+7:8i].
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No memory op: outputs equal the ex_* inputs combinationally, stallreq = 0.
  - Legal memory op: stallreq = 1 combinationally in the same cycle. mem_wreg = 0 (bubble). Next state is ACCESS with i = 0.
- ACCESS:
  - stallreq = 1, mem_wreg = 0.
  - ram_req = 1, with ram_we/ram_addr/ram_dout for byte i held stable until ram_ack.
  - On ram_ack:
    - Loads latch ram_din into buffer byte i.
    - If i = N-1, go to DONE and drop ram_req next cycle.
    - Otherwise i += 1, and the next request is presented next cycle with no idle gap required.
  - ram_ack in IDLE or DONE is ignored.
- DONE (exactly 1 cycle):
  - stallreq = 0, mem_wd = ex_wd, mem_wreg = ex_wreg.
  - Loads: mem_wdata = buffer extended to 32 bits.
    - LB/LH sign-extend from bit 7/15.
    - LBU/LHU zero-extend.
    - LW takes the buffer as-is.
  - Stores: mem_wdata = ex_wdata (ex_wreg is expected to be 0).
  - Next state is IDLE. The inputs now carry the next instruction, which is evaluated in IDLE that cycle.
- Inputs are held stable by the freeze while stallreq = 1. The block does not re-sample ex_* mid-sequence except via the combinational paths.
- Latency: memory op with per-byte ack latency L occupies N·L + 1 cycles of stall, plus 1 DONE cycle.
- ram_addr/ram_we/ram_dout are registered. ram_req is registered and cleared asynchronously by reset.

Test Plan:
- ADD passthrough: ex_wd = 5, ex_wreg = 1, ex_wdata = 0x1234, no mem op → same cycle mem_wd = 5, mem_wreg = 1, mem_wdata = 0x1234, stallreq = 0, ram_req never 1.
- LW at 0x100, memory bytes 0x100..0x103 = 0x78, 0x56, 0x34, 0x12, ack latency 1 → 4 requests at 0x100..0x103 with ram_we = 0; stallreq high until DONE; DONE shows mem_wdata = 0x12345678, mem_wreg = 1.
- LB at 0x201 with byte 0x80 → one request, mem_wdata = 0xFFFFFF80. Same with LBU → 0x00000080. LH at 0x203 (misaligned) with bytes 0xFE, 0x7F → addresses 0x203, 0x204, mem_wdata = 0x00007FFE.
- SW at 0x300, sdata = 0xDEADBEEF, ack latency 3 → bytes EF, BE, AD, DE to 0x300..0x303, each held 3 cycles; DONE occurs 13 cycles after IDLE detect; stallreq = 0 in DONE.
- Back-to-back LW then ADD → ADD result appears the cycle after DONE with no extra bubble. Spurious ram_ack pulse in IDLE → no state change.
- rst asserted low while in ACCESS on byte 2 of a SW → ram_req = 0 and stallreq = 0 immediately. After release, state is IDLE and the next load restarts at byte 0.
